// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes
// little-endian 32-bit words into instruction memory, holding the CPU in reset until done.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | after reset, waiting for START
// S_HDR_LO | waiting for word count low byte
// S_HDR_HI | waiting for word count high byte
// S_DATA   | assembling data words, one write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | image verified, CPU released
// S_ERR    | oversize count or checksum mismatch, CPU held
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0]     DEPTH    = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WIDX_ONE = 1;

  state_t          state_q, state_d;
  logic [15:0]     n_q, n_d;
  // One extra bit so the index can reach N = 2^ADDR_W without wrapping.
  logic [ADDR_W:0] word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     asm_q, asm_d;
  logic [7:0]      csum_q, csum_d;
  logic            we_q, we_d;
  logic [31:0]     wa_q, wa_d;
  logic [31:0]     wd_q, wd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            hold_q, hold_d;

  logic            accept;
  logic            enter_hdr;
  logic [15:0]     n_full;

  assign BYTE_READY = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept     = BYTE_VALID && BYTE_READY;
  assign n_full     = {BYTE_IN, n_q[7:0]};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    enter_hdr  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) enter_hdr = 1'b1;
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = BYTE_IN;
          state_d  = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d = n_full;
          if ({1'b0, n_full} > DEPTH)  state_d = S_ERR;
          else if (n_full == 16'd0)    state_d = S_CSUM;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q + BYTE_IN;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = BYTE_IN;
            2'd1: asm_d[15:8]  = BYTE_IN;
            2'd2: asm_d[23:16] = BYTE_IN;
            default: begin
              // Write register is separate from the assembly register, so the
              // next word can start arriving while this one is on the port.
              we_d       = 1'b1;
              wd_d       = {BYTE_IN, asm_q};
              wa_d       = 32'({word_idx_q[ADDR_W-1:0], 2'b00});
              word_idx_d = word_idx_q + WIDX_ONE;
              if (17'(word_idx_q) + 17'd1 == {1'b0, n_q}) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) state_d = (BYTE_IN == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_hdr) begin
      state_d    = S_HDR_LO;
      word_idx_d = '0;
      byte_idx_d = '0;
      asm_d      = '0;
      csum_d     = '0;
    end

    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign WE       = we_q;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign CPU_HOLD = hold_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 256-word instruction memory. Takes a byte stream with a valid/ready handshake from a host link such as a UART receiver, assembles little-endian 32-bit words, and drives a one-word-per-cycle write port into the memory.
- Holds the CPU in reset until a complete, checksum-verified image is loaded.
- Sits between the host link and the instruction memory write port.

Parameters:
- ADDR_W, 8, word-address width. Memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that begins a load. Accepted only in IDLE, DONE or ERR.
- BYTE_IN  in  8  stream byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- WE  out  1  instruction memory write enable, one-cycle pulse.
- WA  out  32  write byte address, word aligned (WA[1:0]=0). The memory indexes it with WA[ADDR_W+1:2].
- WD  out  32  write data.
- CPU_HOLD  out  1  high keeps the core in reset.
- DONE  out  1  image loaded and checksum matched.
- ERR  out  1  load failed.

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - state=IDLE
  - BYTE_READY=0, WE=0, WA=0, WD=0
  - CPU_HOLD=1, DONE=0, ERR=0
  - internal word count, byte index, word index and checksum all 0.
- Handshake: a byte is accepted on a rising edge where BYTE_VALID and BYTE_READY are both 1. BYTE_READY is 1 only in HDR_LO, HDR_HI, DATA and CSUM. BYTE_VALID gaps of any length are legal.
- Frame format, in order:
  - count low byte, then count high byte (N, 16 bits, little-endian);
  - 4N data bytes, each word least-significant byte first;
  - one checksum byte, equal to the sum of all data bytes mod 256. Header bytes are excluded.
- States:
  - IDLE: START -> HDR_LO.
  - HDR_LO: accept -> latch N[7:0] -> HDR_HI.
  - HDR_HI: accept -> latch N[15:8]. If N > 2^ADDR_W -> ERR. If N = 0 -> CSUM. Otherwise -> DATA.
  - DATA: each accepted byte goes into lane byte_idx of the assembly register and is added to the running checksum. On the 4th byte of a word:
    - the next cycle WE=1, WD=assembled word, WA={word_idx,2'b00} zero-extended;
    - word_idx increments after the write.
    - After the Nth word is accepted -> CSUM.
  - CSUM: accept -> equal to running sum -> DONE, else -> ERR.
  - DONE: DONE=1, CPU_HOLD=0. START -> HDR_LO.
  - ERR: ERR=1, CPU_HOLD=1. START -> HDR_LO.
- Entering HDR_LO from any state clears DONE, ERR, word_idx, byte_idx and the checksum, and sets CPU_HOLD=1.
- Write latency: WE asserts exactly one cycle after the accepting edge of a word's 4th byte. At most one WE per 4 accepted bytes, so WE is never back-to-back.
- Accepting a byte in the same cycle WE is high is legal. The write register must not be corrupted by it.
- Words are written in order from address 0. No write ever occurs to word index ≥ N or ≥ 2^ADDR_W.
- On a checksum mismatch, words already written stay in memory. CPU_HOLD stays 1 until a successful reload.
- START in HDR_LO, HDR_HI, DATA or CSUM is ignored.
- rst_n low mid-load aborts immediately to the reset values. A half-assembled word is discarded and never written.
- N = 2^ADDR_W (256) is legal. word_idx must not overflow into WA bit ADDR_W+2.

Test Plan:
- Load of 2 words: START, then bytes 02 00 93 00 50 00 13 01 10 00 07. Required: WE pulses with WA=0x0/WD=0x00500093 and WA=0x4/WD=0x00100113; then DONE=1, CPU_HOLD=0, ERR=0.
- Same frame with checksum byte 08. Required: both writes occur, then ERR=1, DONE=0, CPU_HOLD=1.
- Header 01 01 (N=257). Required: ERR=1 after the second byte, zero WE pulses, BYTE_READY=0.
- Header 00 00 then checksum 00. Required: DONE=1, zero WE pulses. Header 00 00 with checksum 05 -> ERR=1.
- 2-word frame with 0–5 random idle cycles between bytes, plus a START pulse mid-frame. Required: identical writes and DONE as the gap-free case; the mid-frame START is ignored.
- Mid-frame reset and restart:
  - rst_n pulsed low after the 6th byte of the 2-word frame. Required: outputs go to their reset values immediately, and only one WE (WA=0) has occurred.
  - Then START plus a full 256-word frame with correct checksum. Required: last write WA=0x3FC, DONE=1.
  - Then a second START. Required: DONE clears and CPU_HOLD=1.
